// File: rtl/expr_emit_if.sv
// expr_emit_if -- character stream carrying the emitted expression.
//   out_char  : ASCII character offered by the producer
//   out_valid : out_char is valid this cycle
//   out_ready : consumer accepts out_char this cycle
// A character moves on a cycle where out_valid & out_ready are both 1.
interface expr_emit_if;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_char, output out_valid, input out_ready);
  modport slave  (input out_char, input out_valid, output out_ready);
endinterface

// File: rtl/expr_emit.sv
// expr_emit -- serialises one arithmetic expression per request as ASCII.
// A request is n BCD operands joined by '+'/'*' operators, optionally
// wrapped in parentheses, emitted one character per handshake on o.
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-high reset
//   start  : request strobe, sampled only while busy=0
//   n      : operand count (1..MAX_N)
//   digits : BCD operands, operand i in [4i+3:4i], operand 0 emitted first
//   ops    : operator after operand i in bit i (0 '+', 1 '*')
//   paren  : wrap the expression in '(' ... ')'
//   o      : character stream (master side)
//   busy   : request in progress, start ignored
//   done   : one-cycle pulse after the last character is accepted
//   err    : one-cycle pulse when a request is rejected
module expr_emit #(
  parameter int MAX_N = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [3:0]         n,
  input  logic [4*MAX_N-1:0] digits,
  input  logic [MAX_N-2:0]   ops,
  input  logic               paren,
  expr_emit_if.master        o,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, OPEN, DIGIT, OP, CLOSE, FIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  n_q, n_d;
  // Operands and operators are held zero-padded to the MAX_N=8 width so
  // that a 3-bit k can index them for every legal MAX_N.
  logic [31:0] digits_q, digits_d;
  logic [7:0]  ops_q, ops_d;
  logic        paren_q, paren_d;
  logic        err_q, err_d;

  logic [MAX_N-1:0] digit_bad;
  logic             req_bad;
  logic [3:0]       cur_digit;
  logic             last_digit;
  logic             hs;
  logic             valid_c;
  logic [7:0]       char_c;

  // Only operands that will actually be emitted must be valid BCD.
  for (genvar gi = 0; gi < MAX_N; gi++) begin : g_chk
    assign digit_bad[gi] = (n > 4'(gi)) && (digits[4*gi +: 4] > 4'd9);
  end

  assign req_bad = (n == 4'd0) || (n > 4'(MAX_N)) ||
                   (paren && (n < 4'd2)) || (|digit_bad);

  assign cur_digit  = digits_q[{k_q, 2'b00} +: 4];
  assign last_digit = ({1'b0, k_q} == (n_q - 4'd1));
  assign hs         = valid_c & o.out_ready;

  // Character and valid depend on state only, so they are stable while
  // stalled and drop to zero the moment clr resets the state.
  always_comb begin
    valid_c = 1'b0;
    char_c  = 8'h00;
    case (state_q)
      OPEN:  begin valid_c = 1'b1; char_c = 8'h28; end
      DIGIT: begin valid_c = 1'b1; char_c = 8'h30 + {4'h0, cur_digit}; end
      OP:    begin valid_c = 1'b1; char_c = ops_q[k_q] ? 8'h2A : 8'h2B; end
      CLOSE: begin valid_c = 1'b1; char_c = 8'h29; end
      default: ;
    endcase
  end

  assign o.out_valid = valid_c;
  assign o.out_char  = char_c;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign err         = err_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    paren_d  = paren_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            n_d      = n;
            digits_d = 32'(digits);
            ops_d    = 8'(ops);
            paren_d  = paren;
            k_d      = 3'd0;
            state_d  = paren ? OPEN : DIGIT;
          end
        end
      end
      OPEN:  if (hs) state_d = DIGIT;
      DIGIT: begin
        if (hs) begin
          if (last_digit) state_d = paren_q ? CLOSE : FIN;
          else            state_d = OP;
        end
      end
      OP: begin
        if (hs) begin
          state_d = DIGIT;
          k_d     = k_q + 3'd1;
        end
      end
      CLOSE: if (hs) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      n_q      <= 4'd0;
      digits_q <= 32'd0;
      ops_q    <= 8'd0;
      paren_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      digits_q <= digits_d;
      ops_q    <= ops_d;
      paren_q  <= paren_d;
      err_q    <= err_d;
    end
  end

endmodule
